psimd_lsu: RTL and testbench
============================

// Module: psimd_lsu
// PURPOSE
//  Load/store unit directly upstream of the PSIMD data memory.
//  Takes one vector load/store request from execute, forms the effective address
//  and drives the memory's address/data_out_to_mem/mem_read/mem_write for one cycle.
//  Returns the 64-bit packed 4x16-bit DLFloat load data, or a store ack, via valid/ready.
// PARAMETERS
//  ADDR_W     32   effective address width (matches memory address port)
//  DATA_W     64   vector width, 4 lanes x 16-bit DLFloat
//  IMM_W      12   signed offset width
//  MEM_DEPTH  256  memory entries; legal addresses are 0..MEM_DEPTH-1
//  ALIGN      8    required address alignment, in address units
// PORTS
//  clk               in   1       clock, rising edge
//  rst_n             in   1       asynchronous active-low reset
//  req_valid         in   1       request present
//  req_ready         out  1       LSU can accept; equals (state==IDLE)
//  req_store         in   1       0 = load, 1 = store
//  req_base          in   ADDR_W  base address
//  req_imm           in   IMM_W   signed offset
//  req_wdata         in   DATA_W  store data
//  req_rd            in   5       destination vector register (loads)
//  resp_valid        out  1       response held until resp_ready
//  resp_ready        in   1       consumer accepts the response
//  resp_data         out  DATA_W  load data; 0 for stores and errors
//  resp_rd           out  5       echo of req_rd
//  resp_err          out  1       misaligned or out-of-range address; no access made
//  address           out  ADDR_W  to memory
//  data_out_to_mem   out  DATA_W  to memory
//  mem_read          out  1       to memory
//  mem_write         out  1       to memory
//  data_in_from_mem  in   DATA_W  from memory; combinational read, valid in the same cycle
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
//    Also address=0, data_out_to_mem=0, mem_read=0, mem_write=0. All internal registers cleared.
//  - Effective address: ea = req_base + sign_extend(req_imm), mod 2^ADDR_W.
//  - Error condition: (ea % ALIGN != 0) or (ea >= MEM_DEPTH).
//  - IDLE: on req_valid & req_ready, latch ea, op, wdata and rd.
//    Error -> go to RESP with resp_err=1; mem_read and mem_write never assert.
//    No error -> go to ACCESS.
//  - ACCESS (exactly 1 cycle):
//    address=ea. mem_read=~store, mem_write=store, data_out_to_mem=wdata.
//    Load captures data_in_from_mem into resp_data at the clock edge ending ACCESS.
//    Then go to RESP.
//  - RESP: resp_valid=1; outputs stable until resp_ready. On resp_valid & resp_ready go to IDLE.
//  - Latency: request accepted at edge N -> resp_valid high after edge N+2 (error: after N+1).
//    Throughput: 1 request per 3 cycles minimum.
//  - Memory outputs are 0 in every state except ACCESS; mem_read and mem_write are never both 1.
//  - req_valid while not IDLE is ignored; the requester holds the request.
//  - Reset asserted mid-ACCESS drops mem_read and mem_write immediately (asynchronous), with no retry.
// CONFIGURATION
//  PSIMD_LSU_LANE_MASK_EN
//   Defined:
//    - Adds input req_mask[3:0]; bit i enables lane i, bits [16i+15:16i].
//    - A store with mask != 4'hF uses state RMW_RD (mem_read=1, capture the old word), then ACCESS.
//      ACCESS writes the merged word: masked lanes from wdata, others from the old word.
//      Adds 1 cycle of latency.
//    - A store with mask==4'h0 skips memory and goes straight to RESP, resp_err=0.
//    - Loads ignore the mask.
//   Undefined: no req_mask port, no RMW_RD state; every store writes all 64 bits.
// TESTING
//  1) Reset, then load base=0x10, imm=0 -> address=16, mem_read for 1 cycle.
//     resp_valid 2 cycles after accept; resp_data=0x4000400040004000, resp_err=0.
//  2) Store base=0x20, imm=-8, wdata=0x1234... -> address=24, one mem_write pulse.
//     Load of 24 then returns the stored word.
//  3) Load base=0x11 -> resp_err=1 one cycle after accept, resp_data=0.
//     Load base=0xF8, imm=8 (ea=256) -> resp_err=1. Neither touches memory.
//  4) Hold resp_ready=0 for 3 cycles -> resp_valid, resp_data and resp_rd stable; req_ready=0.
//     A new req_valid is ignored until the handshake completes.
//  5) Assert rst_n=0 during the ACCESS cycle of a store -> mem_write falls in the same cycle.
//     All outputs go to reset values; req_ready=1 once rst_n deasserts.
//  6) [MASK_EN] Address 8 holds 0x3e003e003e003e00. Store mask=4'b0101, wdata=0xFFFF...FFFF.
//     Reload returns 0x3e00FFFF3e00FFFF; resp_valid arrives 1 cycle later than in test 2.

Source files
------------

// File: rtl/psimd_lsu_if.sv
// Request/response and memory-side signals of the PSIMD load/store unit.
// The lane-mask input exists only when PSIMD_LSU_LANE_MASK_EN is defined.
interface psimd_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int IMM_W  = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_base;
  logic [IMM_W-1:0]  req_imm;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;
`ifdef PSIMD_LSU_LANE_MASK_EN
  logic [3:0]        req_mask;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out_to_mem;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] data_in_from_mem;

  modport slave (
`ifdef PSIMD_LSU_LANE_MASK_EN
    input  req_mask,
`endif
    input  req_valid, req_store, req_base, req_imm, req_wdata, req_rd,
    input  resp_ready, data_in_from_mem,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err,
    output address, data_out_to_mem, mem_read, mem_write
  );

  modport master (
`ifdef PSIMD_LSU_LANE_MASK_EN
    output req_mask,
`endif
    output req_valid, req_store, req_base, req_imm, req_wdata, req_rd,
    output resp_ready, data_in_from_mem,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
    input  address, data_out_to_mem, mem_read, mem_write
  );
endinterface

// File: rtl/psimd_lsu.sv
// PSIMD load/store unit: one vector request at a time, single-cycle memory access.
// Optional per-lane store masking (read-modify-write) under PSIMD_LSU_LANE_MASK_EN.
module psimd_lsu #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int IMM_W     = 12,
  parameter int MEM_DEPTH = 256,
  parameter int ALIGN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  psimd_lsu_if.slave bus
);
  localparam int LANES  = 4;
  localparam int LANE_W = DATA_W / LANES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef PSIMD_LSU_LANE_MASK_EN
    RMW_RD = 2'd3,
`endif
    RESP   = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] calc_ea(input logic [ADDR_W-1:0] base,
                                                input logic signed [IMM_W-1:0] imm);
    return base + ADDR_W'(imm);
  endfunction

  // ALIGN is a power of two, so the low bits give the remainder.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] ea);
    return ((ea & ADDR_W'(ALIGN - 1)) != '0) || (ea >= ADDR_W'(MEM_DEPTH));
  endfunction

`ifdef PSIMD_LSU_LANE_MASK_EN
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [LANES-1:0]  mask);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      m[i*LANE_W +: LANE_W] = mask[i] ? new_w[i*LANE_W +: LANE_W] : old_w[i*LANE_W +: LANE_W];
    return m;
  endfunction
`endif

  state_t            state, state_nx;
  logic [ADDR_W-1:0] req_ea;
  logic              req_err;
  logic [ADDR_W-1:0] ea_p0;
  logic              store_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] resp_data_p1;
  logic              resp_err_p1;
  logic [DATA_W-1:0] wr_word;
`ifdef PSIMD_LSU_LANE_MASK_EN
  logic [LANES-1:0]  req_mask_eff;
  logic [LANES-1:0]  mask_p0;
  logic [DATA_W-1:0] old_p0;

  // Loads behave as full-width so they never enter the read-modify-write path.
  assign req_mask_eff = bus.req_store ? bus.req_mask : '1;
  assign wr_word      = merge_lanes(old_p0, wdata_p0, mask_p0);
`else
  assign wr_word      = wdata_p0;
`endif

  assign req_ea  = calc_ea(bus.req_base, bus.req_imm);
  assign req_err = addr_bad(req_ea);

  assign bus.resp_data = resp_data_p1;
  assign bus.resp_err  = resp_err_p1;
  assign bus.resp_rd   = rd_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Memory strobes are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    state_nx            = state;
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.address         = '0;
    bus.data_out_to_mem = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                   state_nx = RESP;
`ifdef PSIMD_LSU_LANE_MASK_EN
          else if (req_mask_eff == '0)   state_nx = RESP;
          else if (req_mask_eff != '1)   state_nx = RMW_RD;
`endif
          else                           state_nx = ACCESS;
        end
      end
`ifdef PSIMD_LSU_LANE_MASK_EN
      RMW_RD: begin
        bus.address  = ea_p0;
        bus.mem_read = 1'b1;
        state_nx     = ACCESS;
      end
`endif
      ACCESS: begin
        bus.address         = ea_p0;
        bus.mem_read        = ~store_p0;
        bus.mem_write       = store_p0;
        bus.data_out_to_mem = wr_word;
        state_nx            = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch (_p0) and response registers (_p1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_p0        <= '0;
      store_p0     <= 1'b0;
      wdata_p0     <= '0;
      rd_p0        <= '0;
      resp_data_p1 <= '0;
      resp_err_p1  <= 1'b0;
`ifdef PSIMD_LSU_LANE_MASK_EN
      mask_p0      <= '0;
      old_p0       <= '0;
`endif
    end else begin
      if (state == IDLE && bus.req_valid) begin
        ea_p0        <= req_ea;
        store_p0     <= bus.req_store;
        wdata_p0     <= bus.req_wdata;
        rd_p0        <= bus.req_rd;
        resp_data_p1 <= '0;
        resp_err_p1  <= req_err;
`ifdef PSIMD_LSU_LANE_MASK_EN
        mask_p0      <= req_mask_eff;
`endif
      end
`ifdef PSIMD_LSU_LANE_MASK_EN
      if (state == RMW_RD) old_p0 <= bus.data_in_from_mem;
`endif
      if (state == ACCESS && !store_p0) resp_data_p1 <= bus.data_in_from_mem;
    end
  end
endmodule

// File: tb/tb_psimd_lsu.sv
// Bench for psimd_lsu: directed cases then random traffic against a word-level memory model.
module tb_psimd_lsu;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  psimd_lsu_if bus();
  psimd_lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [63:0] INIT_W = 64'h4000400040004000;
  localparam logic [63:0] INIT_8 = 64'h3e003e003e003e00;

  logic [63:0] mem     [0:255];
  logic [63:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8) ? INIT_8 : INIT_W;
    end else if (bus.mem_write && bus.address < 32'd256) begin
      mem[bus.address[7:0]] <= bus.data_out_to_mem;
    end
  end

  always_comb bus.data_in_from_mem = (bus.address < 32'd256) ? mem[bus.address[7:0]] : 64'h0;

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = (i == 8) ? INIT_8 : INIT_W;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) chk("ready_timeout", 64'(bus.req_ready), 64'h1);
  endtask

  task automatic do_req(input bit st, input logic [31:0] base, input logic [11:0] imm,
                        input logic [63:0] wd, input logic [4:0] rd, input logic [3:0] mask,
                        input int hold, input bit poke);
    logic [31:0] ea;
    logic [3:0]  eff_mask;
    logic [63:0] merged, exp_data;
    bit          err, skip, rmw;
    int          off, exp_lat, lat, rdc, wrc;
    off = int'($signed(imm));
    ea  = base + 32'(off);
    err = (ea % 8 != 0) || (ea >= 256);
`ifdef PSIMD_LSU_LANE_MASK_EN
    eff_mask = st ? mask : 4'hF;
`else
    eff_mask = 4'hF;
`endif
    skip = st && !err && (eff_mask == 4'h0);
    rmw  = st && !err && (eff_mask != 4'h0) && (eff_mask != 4'hF);
    merged = 64'h0;
    for (int l = 0; l < 4; l++)
      merged[16*l +: 16] = eff_mask[l] ? wd[16*l +: 16] : (err ? 16'h0 : ref_mem[ea[7:0]][16*l +: 16]);
    exp_data = (!st && !err) ? ref_mem[ea[7:0]] : 64'h0;
    exp_lat  = (err || skip) ? 1 : (rmw ? 3 : 2);

    wait_ready();
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_base  = base;
    bus.req_imm   = imm;
    bus.req_wdata = wd;
    bus.req_rd    = rd;
`ifdef PSIMD_LSU_LANE_MASK_EN
    bus.req_mask  = mask;
`endif
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    lat = 0; rdc = 0; wrc = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      chk("excl", 64'(bus.mem_read & bus.mem_write), 64'h0);
      if (bus.mem_read) rdc++;
      if (bus.mem_write) begin
        wrc++;
        chk("wdata", bus.data_out_to_mem, merged);
      end
      if (bus.mem_read || bus.mem_write) chk("addr", 64'(bus.address), 64'(ea));
      if (bus.resp_valid) lat = c;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rd_pulses", 64'(rdc), 64'((!err && !st) || rmw));
    chk("wr_pulses", 64'(wrc), 64'(st && !err && !skip));
    chk("resp_data", bus.resp_data, exp_data);
    chk("resp_err", 64'(bus.resp_err), 64'(err));
    chk("resp_rd", 64'(bus.resp_rd), 64'(rd));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_store = 1'b1;
        bus.req_base  = 32'h0;
        bus.req_imm   = 12'h0;
        bus.req_wdata = '1;
      end
      @(negedge clk);
      chk("hold_valid", 64'(bus.resp_valid), 64'h1);
      chk("hold_data", bus.resp_data, exp_data);
      chk("hold_rd", 64'(bus.resp_rd), 64'(rd));
      chk("hold_ready", 64'(bus.req_ready), 64'h0);
      chk("hold_mem", 64'(bus.mem_read | bus.mem_write), 64'h0);
    end
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("done_valid", 64'(bus.resp_valid), 64'h0);
    chk("done_ready", 64'(bus.req_ready), 64'h1);
    chk("done_mem", 64'(bus.mem_read | bus.mem_write), 64'h0);

    if (st && !err && !skip) ref_mem[ea[7:0]] = merged;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, 64'(bus.req_ready), 64'h1);
    chk({pfx, "_resp_valid"}, 64'(bus.resp_valid), 64'h0);
    chk({pfx, "_resp_data"}, bus.resp_data, 64'h0);
    chk({pfx, "_resp_rd"}, 64'(bus.resp_rd), 64'h0);
    chk({pfx, "_resp_err"}, 64'(bus.resp_err), 64'h0);
    chk({pfx, "_address"}, 64'(bus.address), 64'h0);
    chk({pfx, "_dout"}, bus.data_out_to_mem, 64'h0);
    chk({pfx, "_mem_read"}, 64'(bus.mem_read), 64'h0);
    chk({pfx, "_mem_write"}, 64'(bus.mem_write), 64'h0);
  endtask

  initial begin
    int k;
    logic [31:0] rb;
    logic [11:0] ri;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_base   = '0;
    bus.req_imm    = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    bus.resp_ready = 1'b0;
`ifdef PSIMD_LSU_LANE_MASK_EN
    bus.req_mask   = 4'hF;
`endif
    ref_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_req(1'b0, 32'h10, 12'h0, 64'h0, 5'd3, 4'hF, 0, 1'b0);
    do_req(1'b1, 32'h20, 12'hFF8, 64'h123456789ABCDEF0, 5'd4, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'd24, 12'h0, 64'h0, 5'd5, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h11, 12'h0, 64'h0, 5'd6, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'hF8, 12'h008, 64'h0, 5'd7, 4'hF, 0, 1'b0);
    do_req(1'b1, 32'h0, 12'hFF8, 64'hDEAD, 5'd8, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h40, 12'h0, 64'h0, 5'd9, 4'hF, 3, 1'b1);

    // Reset during the ACCESS cycle of a store.
    wait_ready();
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_base  = 32'h30;
    bus.req_imm   = 12'h0;
    bus.req_wdata = 64'hA5A5A5A5A5A5A5A5;
    bus.req_rd    = 5'd10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wr", 64'(bus.mem_write), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_reset();
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'h1);
    do_req(1'b0, 32'h30, 12'h0, 64'h0, 5'd11, 4'hF, 0, 1'b0);

`ifdef PSIMD_LSU_LANE_MASK_EN
    do_req(1'b0, 32'h8, 12'h0, 64'h0, 5'd12, 4'hF, 0, 1'b0);
    do_req(1'b1, 32'h8, 12'h0, 64'hFFFFFFFFFFFFFFFF, 5'd13, 4'b0101, 0, 1'b0);
    do_req(1'b0, 32'h8, 12'h0, 64'h0, 5'd14, 4'hF, 0, 1'b0);
    chk("mask_word", ref_mem[8], 64'h3e00FFFF3e00FFFF);
    do_req(1'b1, 32'h8, 12'h0, 64'h0, 5'd15, 4'h0, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rb = $urandom;
        ri = 12'($urandom);
      end else begin
        rb = 32'($urandom_range(0, 31) * 8);
        k  = int'($urandom_range(0, 8));
        ri = 12'((k - 4) * 8);
      end
      do_req(1'($urandom), rb, ri, {$urandom, $urandom}, 5'($urandom), 4'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
